// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if
// Bundles the operand, control and result signals of the execute stage.
//   master : pipeline/hazard side (drives operands and control, observes results)
//   slave  : the execute stage itself
// Signals:
//   in_valid, rd1, rd2, imm, pc, br_offset, fwd_mem, fwd_wb,
//   alu_op[2:0], fwd_a[1:0], fwd_b[1:0], alu_src, set_flags, cbz    (to stage)
//   result, out_valid, br_target, stall, negative, zero, overflow,
//   carry_out, zero_eff                                               (from stage)
interface ex_stage_mc_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] fwd_mem;
    logic [WIDTH-1:0] fwd_wb;
    logic [2:0]       alu_op;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             alu_src;
    logic             set_flags;
    logic             cbz;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic [WIDTH-1:0] br_target;
    logic             stall;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             zero_eff;

    modport master (
        output in_valid, rd1, rd2, imm, pc, br_offset, fwd_mem, fwd_wb,
               alu_op, fwd_a, fwd_b, alu_src, set_flags, cbz,
        input  result, out_valid, br_target, stall,
               negative, zero, overflow, carry_out, zero_eff
    );

    modport slave (
        input  in_valid, rd1, rd2, imm, pc, br_offset, fwd_mem, fwd_wb,
               alu_op, fwd_a, fwd_b, alu_src, set_flags, cbz,
        output result, out_valid, br_target, stall,
               negative, zero, overflow, carry_out, zero_eff
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ex_stage_mc
// Execute stage: operand forwarding, ALU, NZVC flag registers with a CBZ
// zero bypass, branch-target adder and an optional iterative multiplier.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high reset
//   bus    : ex_stage_mc_if.slave (operands, control, result, stall, flags)
// Parameters:
//   WIDTH    : datapath width (>= 8)
//   BR_SHIFT : left shift applied to br_offset
// Build option:
//   MULT_EN  : when defined, op 111 runs on a WIDTH-step shift-add multiplier
//              that stalls upstream; when undefined op 111 returns 0 in one
//              cycle and stall is tied low.
module ex_stage_mc #(
    parameter int WIDTH    = 64,
    parameter int BR_SHIFT = 2
) (
    input logic          clk,
    input logic          reset,
    ex_stage_mc_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] fwd_b_s;
    logic [WIDTH-1:0] op_b_s;
    logic [WIDTH:0]   add_ext_s;
    logic [WIDTH:0]   sub_ext_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic [WIDTH-1:0] result_s;
    logic             c_s;
    logic             v_s;
    logic             out_valid_s;
    logic             stall_s;
    logic             res_zero_s;
    logic             negative_r;
    logic             zero_r;
    logic             overflow_r;
    logic             carry_r;

`ifdef MULT_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] mc_a_r;
    logic [WIDTH-1:0] mc_b_r;
    logic [WIDTH-1:0] prod_r;
    logic             mul_req_s;

    assign mul_req_s = bus.in_valid && (bus.alu_op == 3'b111);
`endif

    // Forwarding muxes; alu_src overrides the forwarded B operand with imm.
    always_comb begin
        op_a_s  = bus.rd1;
        fwd_b_s = bus.rd2;
        case (bus.fwd_a)
            2'b01:   op_a_s = bus.fwd_mem;
            2'b10:   op_a_s = bus.fwd_wb;
            default: op_a_s = bus.rd1;
        endcase
        case (bus.fwd_b)
            2'b01:   fwd_b_s = bus.fwd_mem;
            2'b10:   fwd_b_s = bus.fwd_wb;
            default: fwd_b_s = bus.rd2;
        endcase
        if (bus.alu_src) begin
            op_b_s = bus.imm;
        end else begin
            op_b_s = fwd_b_s;
        end
    end

    // Subtraction is A + ~B + 1 so carry_out is the "no borrow" flag.
    assign add_ext_s = {1'b0, op_a_s} + {1'b0, op_b_s};
    assign sub_ext_s = {1'b0, op_a_s} + {1'b0, ~op_b_s} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle ALU with carry and signed-overflow generation.
    always_comb begin
        alu_res_s = '0;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (bus.alu_op)
            3'b000: alu_res_s = op_b_s;
            3'b010: begin
                alu_res_s = add_ext_s[MSB:0];
                alu_c_s   = add_ext_s[WIDTH];
                alu_v_s   = (op_a_s[MSB] == op_b_s[MSB]) && (add_ext_s[MSB] != op_a_s[MSB]);
            end
            3'b011: begin
                alu_res_s = sub_ext_s[MSB:0];
                alu_c_s   = sub_ext_s[WIDTH];
                alu_v_s   = (op_a_s[MSB] != op_b_s[MSB]) && (sub_ext_s[MSB] != op_a_s[MSB]);
            end
            3'b100:  alu_res_s = op_a_s & op_b_s;
            3'b101:  alu_res_s = op_a_s | op_b_s;
            3'b110:  alu_res_s = op_a_s ^ op_b_s;
            default: alu_res_s = '0;
        endcase
    end

`ifdef MULT_EN
    // Multiplier FSM: latch operands on accept, one shift-add step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            mc_a_r  <= '0;
            mc_b_r  <= '0;
            prod_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mul_req_s) begin
                        mc_a_r  <= op_a_s;
                        mc_b_r  <= op_b_s;
                        prod_r  <= '0;
                        count_r <= '0;
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mc_b_r[0]) begin
                        prod_r <= prod_r + mc_a_r;
                    end
                    mc_a_r <= mc_a_r << 1;
                    mc_b_r <= mc_b_r >> 1;
                    if (count_r == LAST_STEP) begin
                        count_r <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                // The held MUL retires here; going straight to IDLE keeps it
                // from being accepted a second time while it is still presented.
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end
`endif

    // Result / valid / stall selection between the ALU and the multiplier.
    always_comb begin
        result_s    = alu_res_s;
        c_s         = alu_c_s;
        v_s         = alu_v_s;
        out_valid_s = bus.in_valid;
        stall_s     = 1'b0;
`ifdef MULT_EN
        case (state_r)
            ST_IDLE: begin
                out_valid_s = bus.in_valid && (bus.alu_op != 3'b111);
                stall_s     = mul_req_s;
            end
            ST_BUSY: begin
                out_valid_s = 1'b0;
                stall_s     = 1'b1;
            end
            ST_DONE: begin
                result_s    = prod_r;
                c_s         = 1'b0;
                v_s         = 1'b0;
                out_valid_s = 1'b1;
                stall_s     = 1'b0;
            end
            default: begin
                out_valid_s = 1'b0;
                stall_s     = 1'b0;
            end
        endcase
`endif
    end

    assign res_zero_s = (result_s == {WIDTH{1'b0}});

    // NZVC registers load only when a completing instruction requests it.
    always_ff @(posedge clk) begin
        if (reset) begin
            negative_r <= 1'b0;
            zero_r     <= 1'b0;
            overflow_r <= 1'b0;
            carry_r    <= 1'b0;
        end else if (out_valid_s && bus.set_flags) begin
            negative_r <= result_s[MSB];
            zero_r     <= res_zero_s;
            overflow_r <= v_s;
            carry_r    <= c_s;
        end
    end

    assign bus.result    = result_s;
    assign bus.out_valid = out_valid_s;
    assign bus.stall     = stall_s;
    assign bus.br_target = bus.pc + (bus.br_offset << BR_SHIFT);
    assign bus.negative  = negative_r;
    assign bus.zero      = zero_r;
    assign bus.overflow  = overflow_r;
    assign bus.carry_out = carry_r;
    // CBZ looks at the value being produced now rather than the stored flag.
    assign bus.zero_eff  = bus.cbz ? res_zero_s : zero_r;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed testbench for ex_stage_mc (WIDTH=64, BR_SHIFT=2).
module tb_ex_stage_mc;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    ex_stage_mc_if #(.WIDTH(64)) bus ();

    ex_stage_mc #(.WIDTH(64), .BR_SHIFT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic src, input logic [63:0] im, input logic sf);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.rd1       = a;
        bus.rd2       = b;
        bus.alu_src   = src;
        bus.imm       = im;
        bus.set_flags = sf;
        bus.fwd_a     = 2'b00;
        bus.fwd_b     = 2'b00;
        bus.cbz       = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.rd1 = 64'd0; bus.rd2 = 64'd0; bus.imm = 64'd0;
        bus.pc = 64'd0; bus.br_offset = 64'd0; bus.fwd_mem = 64'd0; bus.fwd_wb = 64'd0;
        bus.alu_op = 3'b000; bus.fwd_a = 2'b00; bus.fwd_b = 2'b00; bus.alu_src = 1'b0;
        bus.set_flags = 1'b0; bus.cbz = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
    endtask

    task automatic test_add_imm();
        set_op(3'b010, 64'h2AA, 64'h999, 1'b1, 64'd1, 1'b0);
        #1;
        n_cmp++; if (bus.result !== 64'h2AB) begin n_err++; $display("FAIL add_imm_res got %h want 2ab", bus.result); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_imm_valid got %b want 1", bus.out_valid); end
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0000) begin
            n_err++; $display("FAIL add_imm_flags got %b want 0000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
    endtask

    task automatic test_flags();
        set_op(3'b011, 64'd5, 64'd5, 1'b0, 64'd0, 1'b1);
        #1;
        n_cmp++; if (bus.result !== 64'd0) begin n_err++; $display("FAIL sub_res got %h want 0", bus.result); end
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0101) begin
            n_err++; $display("FAIL sub_flags got %b want 0101", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        set_op(3'b010, 64'd1, 64'd1, 1'b0, 64'd0, 1'b0);
        #1;
        n_cmp++; if (bus.result !== 64'd2) begin n_err++; $display("FAIL add11_res got %h want 2", bus.result); end
        tick();
        n_cmp++; if (bus.zero !== 1'b1) begin n_err++; $display("FAIL flag_hold_z got %b want 1", bus.zero); end
        set_op(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
        #1;
        n_cmp++; if (bus.result !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL ovf_res got %h want 8000000000000000", bus.result); end
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b1010) begin
            n_err++; $display("FAIL ovf_flags got %b want 1010", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        // 0xFFFF..F + 1 wraps to 0 with carry and no signed overflow
        set_op(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1);
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0101) begin
            n_err++; $display("FAIL carry_flags got %b want 0101", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        // 3 - 5 borrows: C=0, N=1
        set_op(3'b011, 64'd3, 64'd5, 1'b0, 64'd0, 1'b1);
        #1;
        n_cmp++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub_neg_res got %h want fffffffffffffffe", bus.result); end
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b1000) begin
            n_err++; $display("FAIL sub_neg_flags got %b want 1000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
    endtask

    task automatic test_forward();
        set_op(3'b010, 64'h1111, 64'h2222, 1'b0, 64'd0, 1'b0);
        bus.fwd_a = 2'b01; bus.fwd_mem = 64'h10;
        bus.fwd_b = 2'b10; bus.fwd_wb = 64'h20;
        #1;
        n_cmp++; if (bus.result !== 64'h30) begin n_err++; $display("FAIL fwd_ab got %h want 30", bus.result); end
        bus.alu_src = 1'b1; bus.imm = 64'd4;
        #1;
        n_cmp++; if (bus.result !== 64'h14) begin n_err++; $display("FAIL fwd_imm got %h want 14", bus.result); end
        bus.alu_src = 1'b0; bus.fwd_a = 2'b11; bus.fwd_b = 2'b01;
        #1;
        n_cmp++; if (bus.result !== 64'h1121) begin n_err++; $display("FAIL fwd_11_01 got %h want 1121", bus.result); end
        tick();
    endtask

    task automatic test_logic();
        set_op(3'b100, 64'hC, 64'hA, 1'b0, 64'd0, 1'b0);
        #1;
        n_cmp++; if (bus.result !== 64'h8) begin n_err++; $display("FAIL and got %h want 8", bus.result); end
        bus.alu_op = 3'b101;
        #1;
        n_cmp++; if (bus.result !== 64'hE) begin n_err++; $display("FAIL or got %h want e", bus.result); end
        bus.alu_op = 3'b110;
        #1;
        n_cmp++; if (bus.result !== 64'h6) begin n_err++; $display("FAIL xor got %h want 6", bus.result); end
        bus.alu_op = 3'b000; bus.alu_src = 1'b1; bus.imm = 64'h55;
        #1;
        n_cmp++; if (bus.result !== 64'h55) begin n_err++; $display("FAIL passb got %h want 55", bus.result); end
        bus.alu_op = 3'b001;
        #1;
        n_cmp++; if (bus.result !== 64'd0) begin n_err++; $display("FAIL op001 got %h want 0", bus.result); end
        tick();
        // 5 - 3: C=1, then OR into the msb clears C and sets N
        set_op(3'b011, 64'd5, 64'd3, 1'b0, 64'd0, 1'b1);
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0001) begin
            n_err++; $display("FAIL b2b_sub_flags got %b want 0001", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        set_op(3'b101, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'd0, 1'b1);
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b1000) begin
            n_err++; $display("FAIL b2b_or_flags got %b want 1000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        // in_valid=0: no completion, flags hold even with set_flags
        set_op(3'b011, 64'd7, 64'd7, 1'b0, 64'd0, 1'b1);
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid got %b want 0", bus.out_valid); end
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b1000) begin
            n_err++; $display("FAIL idle_flags got %b want 1000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
    endtask

    task automatic test_mul();
`ifdef MULT_EN
        int n;
        int stall_cnt;
        set_op(3'b111, 64'd7, 64'd6, 1'b0, 64'd0, 1'b1);
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL mul_accept_stall got %b want 1", bus.stall); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mul_accept_valid got %b want 0", bus.out_valid); end
        n = 0;
        stall_cnt = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            if (bus.stall === 1'b1) stall_cnt++;
            tick();
            n++;
        end
        n_cmp++; if (n !== 65) begin n_err++; $display("FAIL mul_latency got %0d want 65", n); end
        n_cmp++; if (stall_cnt !== 65) begin n_err++; $display("FAIL mul_stall_cycles got %0d want 65", stall_cnt); end
        n_cmp++; if (bus.result !== 64'd42) begin n_err++; $display("FAIL mul_res got %h want 2a", bus.result); end
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mul_done_stall got %b want 0", bus.stall); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_cmp++; if ({bus.stall, bus.out_valid} !== 2'b00) begin n_err++; $display("FAIL mul_retire got %b want 00", {bus.stall, bus.out_valid}); end
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0000) begin
            n_err++; $display("FAIL mul_flags got %b want 0000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        tick();
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mul_no_restart got %b want 0", bus.stall); end
`else
        set_op(3'b111, 64'd7, 64'd6, 1'b0, 64'd0, 1'b1);
        #1;
        n_cmp++; if (bus.result !== 64'd0) begin n_err++; $display("FAIL mul_off_res got %h want 0", bus.result); end
        n_cmp++; if ({bus.out_valid, bus.stall} !== 2'b10) begin n_err++; $display("FAIL mul_off_hs got %b want 10", {bus.out_valid, bus.stall}); end
        tick();
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0100) begin
            n_err++; $display("FAIL mul_off_flags got %b want 0100", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
`endif
    endtask

    task automatic test_reset_mid_mul();
        int vcnt;
        set_op(3'b011, 64'd5, 64'd5, 1'b0, 64'd0, 1'b1);
        tick();
`ifdef MULT_EN
        set_op(3'b111, 64'd3, 64'd5, 1'b0, 64'd0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL mid_mul_stall got %b want 1", bus.stall); end
`endif
        reset = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL rst_mul_stall got %b want 0", bus.stall); end
        n_cmp++; if ({bus.negative, bus.zero, bus.overflow, bus.carry_out} !== 4'b0000) begin
            n_err++; $display("FAIL rst_mul_flags got %b want 0000", {bus.negative, bus.zero, bus.overflow, bus.carry_out}); end
        set_op(3'b010, 64'd3, 64'd4, 1'b0, 64'd0, 1'b0);
        #1;
        n_cmp++; if (bus.result !== 64'd7) begin n_err++; $display("FAIL rst_add_res got %h want 7", bus.result); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rst_add_valid got %b want 1", bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 70; i++) begin
            #1;
            if (bus.out_valid === 1'b1 || bus.stall === 1'b1) vcnt++;
            tick();
        end
        n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL rst_discard got %0d want 0", vcnt); end
    endtask

    task automatic test_cbz_branch();
        set_op(3'b010, 64'd1, 64'd1, 1'b0, 64'd0, 1'b1);
        tick();
        n_cmp++; if (bus.zero !== 1'b0) begin n_err++; $display("FAIL cbz_pre_z got %b want 0", bus.zero); end
        set_op(3'b000, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0);
        bus.cbz = 1'b1;
        #1;
        n_cmp++; if (bus.zero_eff !== 1'b1) begin n_err++; $display("FAIL cbz_bypass got %b want 1", bus.zero_eff); end
        bus.rd2 = 64'd9;
        #1;
        n_cmp++; if (bus.zero_eff !== 1'b0) begin n_err++; $display("FAIL cbz_nonzero got %b want 0", bus.zero_eff); end
        bus.cbz = 1'b0; bus.rd2 = 64'd0;
        #1;
        n_cmp++; if (bus.zero_eff !== 1'b0) begin n_err++; $display("FAIL cbz_off got %b want 0", bus.zero_eff); end
        bus.pc = 64'h100; bus.br_offset = 64'h80;
        #1;
        n_cmp++; if (bus.br_target !== 64'h300) begin n_err++; $display("FAIL br_fwd got %h want 300", bus.br_target); end
        bus.br_offset = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        n_cmp++; if (bus.br_target !== 64'hFC) begin n_err++; $display("FAIL br_back got %h want fc", bus.br_target); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        test_reset();
        test_add_imm();
        test_flags();
        test_forward();
        test_logic();
        test_mul();
        test_reset_mid_mul();
        test_cbz_branch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
